seq_magnitude_cmp: RTL
======================

# seq_magnitude_cmp

Parametrised, multi-cycle magnitude comparator: next generation of the team's fixed 4-bit gate-level comparator. It compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, with early termination on the first differing digit. Operands enter and results leave through valid/ready handshakes. It sits between operand registers and downstream control logic where a single-cycle wide compare would break timing.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits compared per cycle; NDIG = WIDTH/DIGIT.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a, b  in  WIDTH  operands.
- is_signed  in  1  two's-complement compare; sampled with operands. Present only with CMP_SIGNED_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- gt, lt, eq  out  1 each  a>b, a<b, a==b; exactly one is high while out_valid.
- cycles  out  $clog2(NDIG+1)  digits examined for this result, 1..NDIG.

## Operation
- FSM with states IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - Capture a and b into shift registers sa and sb.
  - Clear the digit counter.
  - Go to RUN.
- RUN: in_ready=0. Each cycle, compare the top DIGIT bits of sa and sb and increment the counter.
  - Digits differ: latch gt/lt from that digit, go to DONE.
  - Digits equal and this is the last digit: set eq, go to DONE.
  - Otherwise: shift sa and sb left by DIGIT and stay in RUN.
- DONE: out_valid=1; gt, lt, eq and cycles are held stable.
  - On out_ready, go to IDLE.
  - No new operands are accepted in the same cycle; in_ready rises the cycle after.
- Comparison is unsigned by default.
- Input changes during RUN or DONE are ignored.
- in_valid is level-sensitive. A request held across DONE→IDLE is accepted in IDLE.

## Timing
- Reset values: in_ready=1 (state IDLE); out_valid=0; gt=lt=eq=0; cycles=0; sa=sb=0.
- Reset is asynchronous at any time, including mid-RUN or in DONE. After reset deassertion the block is in IDLE and any in-flight compare is lost.
- Latency: the acceptance edge is edge 0. out_valid is high after edge k, where k is the 1-based index of the first differing digit from the MSB, or NDIG when equal. Minimum 1 cycle, maximum NDIG.
- Throughput: one result per k+2 cycles with out_ready held high.
- Backpressure: out_valid stays high with the result frozen until out_ready is sampled high. No result is dropped.
- Counter width covers NDIG exactly; no wrap-around.

## Configuration
- CMP_SIGNED_EN defined:
  - The is_signed port exists.
  - When is_signed=1 at acceptance, bit WIDTH-1 of both captured operands is inverted. The unsigned datapath then yields the two's-complement ordering.
  - Latency rules are unchanged.
- CMP_SIGNED_EN undefined:
  - No is_signed port.
  - Always unsigned.
  - No extra logic.

## Structure
- Package cmp_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a packed result struct {gt, lt, eq};
  - a compile-time check that WIDTH % DIGIT == 0.
- Sub-module cmp_digit: combinational DIGIT-bit compare producing dgt and dlt; equal when both are low. This is the gate-level slice generalised to DIGIT bits.
- The top level holds the FSM, the shift registers, the counter and the result registers.

## Test plan
All cases use WIDTH=16, DIGIT=4, out_ready=1 unless stated.
- Reset: assert rst_n=0 mid-RUN -> out_valid=0, gt=lt=eq=0, in_ready=1 immediately; no stale result after release.
- Equal operands: a=0x1234, b=0x1234 -> eq=1, cycles=4, out_valid 4 cycles after acceptance.
- Early exit: a=0x12A4, b=0x12B4 -> lt=1, cycles=3. Separately, a=0x9000, b=0x1FFF -> gt=1, cycles=1.
- Backpressure: a=0x0001, b=0x0000 with out_ready=0 for 5 cycles -> gt=1, cycles=4 held stable, in_ready=0 throughout. One cycle after out_ready=1, in_ready=1.
- Signed (CMP_SIGNED_EN): a=0x8000, b=0x7FFF.
  - is_signed=1 -> lt=1, cycles=1.
  - is_signed=0 -> gt=1, cycles=1.
- Back-to-back: in_valid held high with three operand pairs -> three results in order, each with the correct k+2 spacing.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM state,
// packed result and the operand/digit width sanity check.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

  // Operands are consumed whole digits at a time, so WIDTH must split evenly.
  function automatic bit width_ok(input int w, input int d);
    return (d > 0) && (w >= d) && ((w % d) == 0);
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// One DIGIT-bit magnitude slice. Equality is implied when both flags are low.
module cmp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             dgt,
  output logic             dlt
);

  // Pure combinational compare of a single digit.
  always_comb begin
    dgt = (x > y);
    dlt = (x < y);
  end

endmodule

// File: rtl/seq_magnitude_cmp.sv
// Multi-cycle MSB-first magnitude comparator with early exit on the first
// differing digit. Define CMP_SIGNED_EN to add the is_signed port, which
// selects a two's-complement compare by flipping both operand sign bits.
module seq_magnitude_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4,
  localparam int NDIG = WIDTH / DIGIT,
  localparam int CW   = $clog2(NDIG + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic [CW-1:0]    cycles
);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("seq_magnitude_cmp: WIDTH must be a positive multiple of DIGIT");
  end

  cmp_state_t       state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    cnt;
  cmp_res_t         res;
  logic             dgt, dlt, last;

  // Sign-bit flip turns two's-complement ordering into unsigned ordering.
`ifdef CMP_SIGNED_EN
  logic [WIDTH-1:0] flip;
  assign flip = {is_signed, {(WIDTH-1){1'b0}}};
`else
  logic [WIDTH-1:0] flip;
  assign flip = '0;
`endif

  cmp_digit #(.DIGIT(DIGIT)) u_dig (
    .x   (sa[WIDTH-1 -: DIGIT]),
    .y   (sb[WIDTH-1 -: DIGIT]),
    .dgt (dgt),
    .dlt (dlt)
  );

  assign last = (cnt == CW'(NDIG - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE, stop on a differing or final digit, drain on out_ready.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)          state_nxt = RUN;
      RUN:     if (dgt || dlt || last) state_nxt = DONE;
      DONE:    if (out_ready)         state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: capture, per-digit shift/count, and result latch; frozen in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      cnt <= '0;
      res <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sa  <= a ^ flip;
          sb  <= b ^ flip;
          cnt <= '0;
          res <= '0;
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (dgt || dlt) begin
            res <= '{gt: dgt, lt: dlt, eq: 1'b0};
          end else if (last) begin
            res <= '{gt: 1'b0, lt: 1'b0, eq: 1'b1};
          end else begin
            sa <= sa << DIGIT;
            sb <= sb << DIGIT;
          end
        end
        default: ;
      endcase
    end
  end

  assign gt     = res.gt;
  assign lt     = res.lt;
  assign eq     = res.eq;
  assign cycles = cnt;

endmodule
